mips_boot_loader: RTL

Upstream companion of the MIPS processor top: receives a program image as a byte stream, writes it word by word into the 512-word instruction memory, and holds the processor in reset until the image has been fully loaded and checksum-verified. It sits between the host/byte source and the processor's instruction memory write port and reset input, replacing the bare testbench reset pulse in system-level runs.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/mips_boot_loader_byte_to_word.sv | 52 +++++
 rtl/mips_boot_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot loader.
// Holds the loader state encoding, the default instruction memory geometry
// and the width of the image checksum byte.
package mips_pkg;

    localparam int DEPTH_DEF  = 512;
    localparam int ADDR_W_DEF = 9;
    localparam int CSUM_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_RUN,
        ST_ERR
    } loader_state_t;

    // True for the states in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/mips_boot_loader_byte_to_word.sv
// byte_to_word: packs a big-endian byte stream into 32-bit words.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   clear         - synchronous restart of the byte position
//   in_valid      - a byte is consumed this cycle
//   in_data       - the byte
//   word_last     - the next consumed byte completes a word
//   word_valid    - one-cycle pulse, word holds a freshly completed word
//   word          - last completed word (MSB first), held between pulses
module byte_to_word
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [CSUM_W-1:0] in_data,
    output logic              word_last,
    output logic              word_valid,
    output logic [31:0]       word
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;

    assign word_last = (byte_cnt == 2'd3);

    // Only the three older bytes are buffered; the fourth goes straight into
    // the output word so it appears the cycle after it is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            shift_q    <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= 2'd0;
                shift_q  <= 24'd0;
            end else if (in_valid) begin
                shift_q  <= {shift_q[15:0], in_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (word_last) begin
                    word       <= {shift_q, in_data};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: receives a program image as a byte stream, writes it into
// the instruction memory and holds the CPU in reset until the image checks out.
// Image: 16-bit word count N, N big-endian words, XOR checksum of the word bytes.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start                 - begin a load (honoured in IDLE and ERR)
//   rx_data/valid/ready   - byte stream handshake
//   imem_we/addr/wdata    - instruction memory write port
//   cpu_reset             - processor reset, released after a verified load
//   done, error           - load outcome
module mips_boot_loader
    import mips_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_next;
    logic [15:0]       len_q;
    logic [15:0]       word_cnt_q;
    logic [CSUM_W-1:0] csum_q;
    logic              accept;
    logic              load_clear;
    logic              data_accept;
    logic [15:0]       len_full;
    logic              len_bad;
    logic              last_word;
    logic              word_last;
    logic              word_valid;
    logic [31:0]       word;

    assign accept      = rx_valid && rx_ready;
    assign load_clear  = ((state_q == ST_IDLE) || (state_q == ST_ERR)) && start;
    assign data_accept = accept && (state_q == ST_DATA);
    assign len_full    = {len_q[15:8], rx_data};
    assign len_bad     = (len_full == 16'd0) || (len_full > 16'(DEPTH));
    // The word counter only advances on the write pulse, so while the last
    // byte of a word is being consumed it still holds that word's index.
    assign last_word   = (word_cnt_q == (len_q - 16'd1));

    assign imem_we    = word_valid;
    assign imem_wdata = word;
    assign imem_addr  = word_cnt_q[ADDR_W-1:0];

    byte_to_word u_byte_to_word (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_clear),
        .in_valid   (data_accept),
        .in_data    (rx_data),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic: every byte-taking state moves only on an accepted byte.
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_next = ST_LEN_HI;
            ST_LEN_HI: if (accept) state_next = ST_LEN_LO;
            ST_LEN_LO: if (accept) state_next = len_bad ? ST_ERR : ST_DATA;
            ST_DATA:   if (accept && word_last && last_word) state_next = ST_CHECK;
            ST_CHECK:  if (accept) state_next = (rx_data == csum_q) ? ST_RUN : ST_ERR;
            ST_RUN:    state_next = ST_RUN;
            ST_ERR:    if (start) state_next = ST_LEN_HI;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state register and never see rx_valid combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rx_ready  <= accepts_bytes(state_next);
            cpu_reset <= (state_next != ST_RUN);
            done      <= (state_next == ST_RUN);
            error     <= (state_next == ST_ERR);
        end
    end

    // Length capture, checksum accumulation and word address counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= 16'd0;
            word_cnt_q <= 16'd0;
            csum_q     <= '0;
        end else if (load_clear) begin
            word_cnt_q <= 16'd0;
            csum_q     <= '0;
        end else begin
            if (accept && (state_q == ST_LEN_HI)) len_q[15:8] <= rx_data;
            if (accept && (state_q == ST_LEN_LO)) len_q[7:0]  <= rx_data;
            if (data_accept) csum_q <= csum_q ^ rx_data;
            if (word_valid) word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

endmodule
